// File: rtl/tile_writeback_if.sv
// rtl/tile_writeback_if.sv - global buffer C access bus between writeback stage and buffer
//
// Signals:
//   C_wr_en     write enable (0 = read request when an index is presented)
//   C_index     word address into global buffer C
//   C_data_in   write data toward the buffer
//   C_data_out  read data from the buffer, valid the cycle after a read index
// Modports: master = writeback stage, slave = buffer.
interface tile_writeback_if #(
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 128
);
  logic                 C_wr_en;
  logic [ADDR_BITS-1:0] C_index;
  logic [DATA_BITS-1:0] C_data_in;
  logic [DATA_BITS-1:0] C_data_out;

  modport master (output C_wr_en, output C_index, output C_data_in, input C_data_out);
  modport slave  (input C_wr_en, input C_index, input C_data_in, output C_data_out);
endinterface

// File: rtl/tile_writeback.sv
// rtl/tile_writeback.sv - drains one 4x4 systolic tile into global buffer C
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start, accumulate      tile-ready pulse and add-into-C select (sampled with start)
//   M, N, tile_m, tile_n   matrix dimensions and tile coordinates
//   row_c0..row_c3         accumulator rows from the array, column 0 in the MSBs
//   busy, done             sequence in progress / one-cycle completion pulse
//   c_bus                  global buffer C port (master side)
module tile_writeback #(
  parameter int ACC_BITS  = 32,
  parameter int LANES     = 4,
  parameter int ADDR_BITS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      accumulate,
  input  logic [7:0]                M,
  input  logic [7:0]                N,
  input  logic [7:0]                tile_m,
  input  logic [7:0]                tile_n,
  input  logic [ACC_BITS*LANES-1:0] row_c0,
  input  logic [ACC_BITS*LANES-1:0] row_c1,
  input  logic [ACC_BITS*LANES-1:0] row_c2,
  input  logic [ACC_BITS*LANES-1:0] row_c3,
  output logic                      busy,
  output logic                      done,
  tile_writeback_if.master          c_bus
);

  localparam int W = ACC_BITS * LANES;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]           state;
  logic [W-1:0]         cap [4];
  logic                 acc_q;
  logic [6:0]           n_tiles_q;
  logic [2:0]           vr_q;
  logic [1:0]           r_q;
  logic [ADDR_BITS-1:0] idx_q;
  logic [W-1:0]         data_q;

  // Start-time decode from the live inputs; these feed the first address
  // directly because cap/n_tiles are only being loaded on the same edge.
  logic [6:0]           n_tiles_in;
  logic signed [10:0]   rows_left;
  logic [2:0]           vr_in;
  logic [ADDR_BITS-1:0] base_addr_in;
  logic [W-1:0]         acc_sum;

  assign n_tiles_in = 7'(({1'b0, N} + 9'd3) >> 2);
  assign rows_left  = $signed({3'b000, M}) - $signed({1'b0, tile_m, 2'b00});

  always_comb begin
    vr_in = 3'd0;
    if (rows_left >= 11'sd4)
      vr_in = 3'd4;
    else if (rows_left > 11'sd0)
      vr_in = rows_left[2:0];
  end

  // Row r address = base + r*n_tiles; rows after the first step by n_tiles,
  // which keeps the multiply off the per-row path. Modulo 2^ADDR_BITS wraps
  // identically either way.
  assign base_addr_in = ADDR_BITS'({tile_m, 2'b00}) * ADDR_BITS'(n_tiles_in)
                      + ADDR_BITS'(tile_n);

  // Independent per-lane adders: no carry crosses a lane boundary.
  always_comb begin
    acc_sum = '0;
    for (int j = 0; j < LANES; j++)
      acc_sum[j*ACC_BITS +: ACC_BITS] = c_bus.C_data_out[j*ACC_BITS +: ACC_BITS]
                                      + cap[r_q][j*ACC_BITS +: ACC_BITS];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      acc_q     <= 1'b0;
      n_tiles_q <= '0;
      vr_q      <= '0;
      r_q       <= '0;
      idx_q     <= '0;
      data_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cap[0]    <= row_c0;
            cap[1]    <= row_c1;
            cap[2]    <= row_c2;
            cap[3]    <= row_c3;
            acc_q     <= accumulate;
            n_tiles_q <= n_tiles_in;
            vr_q      <= vr_in;
            r_q       <= 2'd0;
            if (vr_in == 3'd0) begin
              state <= S_DONE;
            end else begin
              idx_q <= base_addr_in;
              if (accumulate) begin
                state <= S_RD;
              end else begin
                state  <= S_WR;
                data_q <= row_c0;
              end
            end
          end
        end
        S_RD: state <= S_WR;
        S_WR: begin
          // Keep the written sum so C_data_in holds it once the read data moves on.
          if (acc_q)
            data_q <= acc_sum;
          if ({1'b0, r_q} == vr_q - 3'd1) begin
            state <= S_DONE;
          end else begin
            r_q   <= r_q + 2'd1;
            idx_q <= idx_q + ADDR_BITS'(n_tiles_q);
            if (acc_q) begin
              state <= S_RD;
            end else begin
              state  <= S_WR;
              data_q <= cap[r_q + 2'd1];
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy            = (state != S_IDLE);
  assign done            = (state == S_DONE);
  assign c_bus.C_wr_en   = (state == S_WR);
  assign c_bus.C_index   = idx_q;
  // The read word only arrives in the WR cycle, so the accumulate sum is
  // formed there rather than registered ahead of time.
  assign c_bus.C_data_in = (state == S_WR && acc_q) ? acc_sum : data_q;

endmodule

// File: tb/tb_tile_writeback.sv
// tb/tb_tile_writeback.sv - self-checking bench for tile_writeback with buffer C model
module tb_tile_writeback;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         accumulate;
  logic [7:0]   M, N, tile_m, tile_n;
  logic [127:0] row_c0, row_c1, row_c2, row_c3;
  logic         busy, done;

  logic         init_mem;
  logic         poke_en;
  logic [9:0]   poke_addr;
  logic [127:0] poke_data;
  logic [127:0] rd_q;
  logic [127:0] mem     [0:1023];
  logic [127:0] ref_mem [0:1023];

  int n_checks = 0;
  int n_fail   = 0;

  tile_writeback_if #(.ADDR_BITS(16), .DATA_BITS(128)) cbus ();

  tile_writeback #(.ACC_BITS(32), .LANES(4), .ADDR_BITS(16)) dut (
    .clk(clk), .rst(rst), .start(start), .accumulate(accumulate),
    .M(M), .N(N), .tile_m(tile_m), .tile_n(tile_n),
    .row_c0(row_c0), .row_c1(row_c1), .row_c2(row_c2), .row_c3(row_c3),
    .busy(busy), .done(done), .c_bus(cbus)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] init_word(int i);
    return {32'(i) * 32'h9E3779B9, 32'(i) ^ 32'hA5A5A5A5, 32'(i) + 32'h1000, ~32'(i)};
  endfunction

  function automatic logic [127:0] lane_add(logic [127:0] a, logic [127:0] b);
    logic [127:0] s;
    for (int j = 0; j < 4; j++)
      s[127-32*j -: 32] = a[127-32*j -: 32] + b[127-32*j -: 32];
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Buffer C: synchronous read, data valid the cycle after a read index.
  always @(posedge clk) begin
    if (init_mem)
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
    else if (poke_en)
      mem[poke_addr] <= poke_data;
    else if (cbus.C_wr_en)
      mem[cbus.C_index[9:0]] <= cbus.C_data_in;
    if (!cbus.C_wr_en)
      rd_q <= mem[cbus.C_index[9:0]];
  end
  assign cbus.C_data_out = rd_q;

  // All tasks start and end just after a falling edge.
  task automatic poke(input int a, input logic [127:0] d);
    poke_en = 1'b1; poke_addr = 10'(a); poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // Launches one tile with start sampled at the next rising edge (edge 0),
  // then compares every cycle 1..done+1 with a model built from the tile
  // geometry. glitch_cycle > 0 pulses a conflicting start during that cycle.
  task automatic exercise_tile(input string name, input int m, input int n, input int tm,
                               input int tn, input bit acc, input logic [3:0][127:0] rows,
                               input int glitch_cycle);
    int nt, vr, d, a, wc;
    logic         exp_we  [0:10];
    logic         exp_ci  [0:10];
    logic [15:0]  exp_idx [0:10];
    logic [127:0] exp_dat [0:10];
    nt = (n + 3) / 4;
    vr = m - 4 * tm;
    if (vr < 0) vr = 0;
    if (vr > 4) vr = 4;
    for (int k = 0; k <= 10; k++) begin
      exp_we[k] = 1'b0; exp_ci[k] = 1'b0; exp_idx[k] = '0; exp_dat[k] = '0;
    end
    for (int r = 0; r < vr; r++) begin
      a  = ((4 * tm + r) * nt + tn) & 16'hFFFF;
      wc = acc ? 2 * r + 2 : r + 1;
      if (acc) begin
        exp_ci[wc-1]  = 1'b1;
        exp_idx[wc-1] = 16'(a);
      end
      exp_we[wc]  = 1'b1;
      exp_ci[wc]  = 1'b1;
      exp_idx[wc] = 16'(a);
      exp_dat[wc] = acc ? lane_add(ref_mem[a], rows[r]) : rows[r];
      ref_mem[a]  = exp_dat[wc];
    end
    d = (vr == 0) ? 1 : (acc ? 2 * vr + 1 : vr + 1);

    start = 1'b1; accumulate = acc;
    M = 8'(m); N = 8'(n); tile_m = 8'(tm); tile_n = 8'(tn);
    row_c0 = rows[0]; row_c1 = rows[1]; row_c2 = rows[2]; row_c3 = rows[3];
    for (int k = 1; k <= d + 1; k++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== (k <= d)) begin
        n_fail++; $display("FAIL %s busy cycle %0d: got %b want %b", name, k, busy, (k <= d));
      end
      n_checks++;
      if (done !== (k == d)) begin
        n_fail++; $display("FAIL %s done cycle %0d: got %b want %b", name, k, done, (k == d));
      end
      n_checks++;
      if (cbus.C_wr_en !== exp_we[k]) begin
        n_fail++; $display("FAIL %s wr_en cycle %0d: got %b want %b", name, k, cbus.C_wr_en, exp_we[k]);
      end
      if (exp_ci[k]) begin
        n_checks++;
        if (cbus.C_index !== exp_idx[k]) begin
          n_fail++; $display("FAIL %s index cycle %0d: got %0d want %0d", name, k, cbus.C_index, exp_idx[k]);
        end
      end
      if (exp_we[k]) begin
        n_checks++;
        if (cbus.C_data_in !== exp_dat[k]) begin
          n_fail++; $display("FAIL %s data cycle %0d: got %h want %h", name, k, cbus.C_data_in, exp_dat[k]);
        end
      end
      start = (k == glitch_cycle);
      if (k == glitch_cycle) begin
        accumulate = ~acc; M = 8'd16; N = 8'd16; tile_m = 8'd0; tile_n = 8'd2;
        row_c0 = rnd128(); row_c1 = rnd128(); row_c2 = rnd128(); row_c3 = rnd128();
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; accumulate = 1'b0; init_mem = 1'b1; poke_en = 1'b0;
    poke_addr = '0; poke_data = '0;
    M = 8'd8; N = 8'd8; tile_m = 8'd0; tile_n = 8'd0;
    row_c0 = rnd128(); row_c1 = rnd128(); row_c2 = rnd128(); row_c3 = rnd128();
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, done, cbus.C_wr_en} !== 3'b000) begin
        n_fail++; $display("FAIL reset flags: got busy/done/wr_en %b want 000", {busy, done, cbus.C_wr_en});
      end
      n_checks++;
      if (cbus.C_index !== 16'd0) begin
        n_fail++; $display("FAIL reset index: got %0d want 0", cbus.C_index);
      end
      n_checks++;
      if (cbus.C_data_in !== 128'd0) begin
        n_fail++; $display("FAIL reset data: got %h want 0", cbus.C_data_in);
      end
    end
    rst = 1'b0; start = 1'b0; init_mem = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_overwrite();
    logic [3:0][127:0] rows;
    rows[0] = {4{32'h0000_00A0}} ^ 128'h1;
    rows[1] = 128'h11111111_22222222_33333333_44444444;
    rows[2] = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    rows[3] = rnd128();
    exercise_tile("overwrite", 8, 8, 1, 1, 1'b0, rows, 0);
  endtask

  task automatic test_accumulate();
    logic [3:0][127:0] rows;
    for (int a = 0; a < 4; a++) poke(a, 128'h00000001_00000002_FFFFFFFF_80000000);
    for (int r = 0; r < 4; r++) rows[r] = 128'h00000002_00000003_00000002_80000000;
    exercise_tile("accumulate", 4, 4, 0, 0, 1'b1, rows, 0);
    n_checks++;
    if (mem[3] !== 128'h00000003_00000005_00000001_00000000) begin
      n_fail++; $display("FAIL accumulate stored word: got %h want 00000003000000050000000100000000", mem[3]);
    end
  endtask

  task automatic test_ragged();
    logic [3:0][127:0] rows;
    for (int r = 0; r < 4; r++) rows[r] = rnd128();
    exercise_tile("ragged_m6n5", 6, 5, 1, 1, 1'b0, rows, 0);
    exercise_tile("ragged_empty", 4, 8, 1, 0, 1'b0, rows, 0);
    exercise_tile("ragged_acc", 7, 9, 1, 2, 1'b1, rows, 0);
  endtask

  task automatic test_start_while_busy();
    logic [3:0][127:0] rows;
    for (int r = 0; r < 4; r++) rows[r] = rnd128();
    exercise_tile("busy_start_wr", 8, 8, 1, 0, 1'b0, rows, 2);
    for (int r = 0; r < 4; r++) rows[r] = rnd128();
    exercise_tile("busy_start_acc", 8, 8, 0, 1, 1'b1, rows, 3);
  endtask

  task automatic test_reset_mid();
    logic [3:0][127:0] rows;
    for (int r = 0; r < 4; r++) rows[r] = rnd128();
    start = 1'b1; accumulate = 1'b0; M = 8'd8; N = 8'd8; tile_m = 8'd0; tile_n = 8'd0;
    row_c0 = rows[0]; row_c1 = rows[1]; row_c2 = rows[2]; row_c3 = rows[3];
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (cbus.C_wr_en !== 1'b1 || cbus.C_index !== 16'd0 || cbus.C_data_in !== rows[0]) begin
      n_fail++; $display("FAIL rst_mid first write: got en %b idx %0d want en 1 idx 0", cbus.C_wr_en, cbus.C_index);
    end
    @(negedge clk);
    n_checks++;
    if (cbus.C_wr_en !== 1'b1 || cbus.C_index !== 16'd2 || cbus.C_data_in !== rows[1]) begin
      n_fail++; $display("FAIL rst_mid second write: got en %b idx %0d want en 1 idx 2", cbus.C_wr_en, cbus.C_index);
    end
    ref_mem[0] = rows[0];
    ref_mem[2] = rows[1];
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({busy, done, cbus.C_wr_en} !== 3'b000 || cbus.C_index !== 16'd0 || cbus.C_data_in !== 128'd0) begin
      n_fail++; $display("FAIL rst_mid outputs: got flags %b idx %0d data %h want all zero",
                         {busy, done, cbus.C_wr_en}, cbus.C_index, cbus.C_data_in);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (cbus.C_wr_en !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid idle: got wr_en %b busy %b want 0 0", cbus.C_wr_en, busy);
      end
    end
    for (int r = 0; r < 4; r++) rows[r] = rnd128();
    exercise_tile("rst_mid_restart", 8, 8, 0, 0, 1'b1, rows, 0);
  endtask

  task automatic test_back_to_back();
    logic [3:0][127:0] rows;
    for (int r = 0; r < 4; r++) rows[r] = rnd128();
    exercise_tile("b2b_first", 12, 12, 2, 2, 1'b0, rows, 0);
    for (int r = 0; r < 4; r++) rows[r] = rnd128();
    exercise_tile("b2b_second", 12, 12, 2, 2, 1'b1, rows, 0);
    exercise_tile("b2b_third", 3, 16, 0, 3, 1'b1, rows, 0);
  endtask

  task automatic test_random();
    logic [3:0][127:0] rows;
    for (int t = 0; t < 30; t++) begin
      for (int r = 0; r < 4; r++) rows[r] = rnd128();
      exercise_tile("random", int'($urandom_range(1, 16)), int'($urandom_range(1, 16)),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), rows, 0);
    end
  endtask

  initial begin
    test_reset();
    test_overwrite();
    test_accumulate();
    test_ragged();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
